// File: rtl/somador_serial_pkg.sv
// somador_serial_pkg: FSM encoding and default width shared by the serial adder files
package somador_serial_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   localparam int WIDTH_DEF = 5;
endpackage

// File: rtl/somador_serial_full_adder.sv
// full_adder_cell: one-bit full adder in sum-of-minterms form
module full_adder_cell (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);
   assign s    = (~a & ~b & cin) | (~a & b & ~cin) | (a & ~b & ~cin) | (a & b & cin);
   assign cout = (~a & b & cin) | (a & ~b & cin) | (a & b & ~cin) | (a & b & cin);
endmodule

// File: rtl/somador_serial.sv
// somador_serial: bit-serial add/subtract, LSB first through a single full-adder cell
module somador_serial
   import somador_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   state_t state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic [CW-1:0] cnt;
   logic carry, cin_msb, s_bit, c_bit, last, go;
   full_adder_cell u_fa (.s(s_bit), .cout(c_bit), .a(a_sh[0]), .b(b_sh[0]), .cin(carry));
   assign last = cnt == CW'(WIDTH - 1);
   assign go   = ready & start;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = go ? SHIFT : (state == SHIFT && last) ? DONE : (state == DONE) ? IDLE : state;
   end
   // the done cycle sits in IDLE but refuses a new start so the handshakes never overlap
   always_comb begin
      ready = state == IDLE && !done;
      busy  = state == SHIFT;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         cin_msb <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= state == DONE;
         if (go) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {s_bit, res_sh[WIDTH-1:1]};
            carry  <= c_bit;
            cnt    <= last ? cnt : cnt + 1'b1;
            if (last) cin_msb <= carry;
         end else if (state == DONE) begin
            sum  <= res_sh;
            cout <= carry;
            ovf  <= cin_msb ^ carry;
         end
      end
endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: scoreboard bench for the serial adder
module tb_somador_serial;
   localparam int W = 5;
   typedef struct packed {logic [W-1:0] s; logic c; logic v;} exp_t;
   logic clk = 0, rst_n = 0, start = 0, sub = 0;
   logic [W-1:0] a = '0, b = '0, sum, sum_prev = '0;
   logic ready, busy, done, cout, ovf;
   exp_t q[$];
   int total = 0, bad = 0, cyc = 0, acc_cyc = 0, ndone = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   somador_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t e;
      logic [W:0] full;
      int ix, iy, r;
      full = {1'b0, x} + {1'b0, (s ? ~y : y)} + (W + 1)'(s);
      ix = x[W-1] ? int'(x) - (1 << W) : int'(x);
      iy = y[W-1] ? int'(y) - (1 << W) : int'(y);
      r = s ? ix - iy : ix + iy;
      e.s = full[W-1:0];
      e.c = full[W];
      e.v = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return e;
   endfunction
   always @(negedge clk) begin
      if (rst_n) begin
         chk("excl", 32'($countones({ready, busy, done}) <= 1), 1);
         if (busy) chk("hold", sum, sum_prev);
         if (done) begin
            ndone++;
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("sum", sum, e.s);
               chk("cout", cout, e.c);
               chk("ovf", ovf, e.v);
               chk("lat", cyc - acc_cyc, 6);
            end
         end
      end
      sum_prev = sum;
   end
   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!ready) chk("ready_timeout", 0, 1);
   endtask
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      wait_ready();
      a = x;
      b = y;
      sub = s;
      start = 1;
      q.push_back(model(x, y, s));
      acc_cyc = cyc + 1;
      @(negedge clk);
      start = 0;
      a = ~x;
      b = ~y;
      sub = ~s;
   endtask
   task automatic wait_idle();
      int t = 0;
      while (q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", q.size(), 0);
         q.delete();
      end
      @(negedge clk);
   endtask
   initial begin
      int n0;
      #12;
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 1);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      do_op(5'b10000, 5'b00001, 0);
      wait_idle();
      do_op(5'b11111, 5'b00001, 0);
      wait_idle();
      do_op(5'b01111, 5'b00001, 0);
      wait_idle();
      do_op(5'b00011, 5'b00101, 1);
      wait_idle();
      do_op(5'b00101, 5'b00011, 1);
      wait_idle();
      n0 = ndone;
      do_op(5'b01010, 5'b00110, 0);
      @(negedge clk);
      a = 5'b11111;
      b = 5'b11111;
      sub = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      wait_idle();
      repeat (10) @(negedge clk);
      chk("single_done", ndone - n0, 1);
      wait_ready();
      a = 5'b00111;
      b = 5'b00010;
      sub = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf, 0);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", ready, 1);
      @(negedge clk);
      rst_n = 1;
      repeat (10) @(negedge clk);
      do_op(5'b01001, 5'b00110, 0);
      wait_idle();
      for (int i = 0; i < 12; i++) do_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_idle();
      do_op(5'b10000, 5'b00001, 1);
      wait_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
